// File: rtl/csr_pkg.sv
// Shared CSR addresses and default test status codes for the counter/status block.
package csr_pkg;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
  localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
  localparam csr_addr_t CSR_MINSTRET      = 12'hB02;
  localparam csr_addr_t CSR_MINSTRETH     = 12'hB82;
  localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
  localparam csr_addr_t CSR_MTEST_STATUS  = 12'h7C0;
  localparam csr_addr_t CSR_CYCLE         = 12'hC00;
  localparam csr_addr_t CSR_CYCLEH        = 12'hC80;
  localparam csr_addr_t CSR_INSTRET       = 12'hC02;
  localparam csr_addr_t CSR_INSTRETH      = 12'hC82;

  localparam logic [31:0] DEFAULT_PASS_CODE = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_FAIL_CODE = 32'hDEAD_0001;

  // Only CY (bit 0) and IR (bit 2) are implemented in mcountinhibit.
  localparam int unsigned INH_CY_BIT = 0;
  localparam int unsigned INH_IR_BIT = 2;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half CSR write; a write to either half blocks that cycle's increment.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] r_cnt;
  logic [63:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) w_cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) w_cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      w_cnt_d = r_cnt + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/csr_counter_unit.sv
// Machine counter/status CSRs: mcycle, minstret, mcountinhibit and mtest_status with
// sticky done/pass flags decoded from terminal test codes.
module csr_counter_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] TEST_PASS_CODE  = DEFAULT_PASS_CODE,
  parameter logic [31:0] TEST_FAIL_CODE  = DEFAULT_FAIL_CODE,
  parameter bit          HAS_USER_SHADOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_w_i,
  input  logic        stall_w_i,
  input  logic [11:0] csr_addr_e_i,
  output logic [31:0] csr_rdata_e_o,
  output logic        csr_illegal_e_o,
  input  logic        csr_we_w_i,
  input  logic [11:0] csr_addr_w_i,
  input  logic [31:0] csr_wdata_w_i,
  output logic        test_done_o,
  output logic        test_pass_o
);

  logic        r_inh_cy;
  logic        r_inh_ir;
  logic [31:0] r_mtest_status;
  logic        r_done;
  logic        r_pass;

  logic        w_retire;
  logic        w_wr_mcycle;
  logic        w_wr_mcycleh;
  logic        w_wr_minstret;
  logic        w_wr_minstreth;
  logic        w_wr_inhibit;
  logic        w_wr_status;
  logic        w_is_terminal;
  logic [63:0] w_cycle;
  logic [63:0] w_instret;

  assign w_retire       = valid_w_i & ~stall_w_i;
  assign w_wr_mcycle    = csr_we_w_i && (csr_addr_w_i == CSR_MCYCLE);
  assign w_wr_mcycleh   = csr_we_w_i && (csr_addr_w_i == CSR_MCYCLEH);
  assign w_wr_minstret  = csr_we_w_i && (csr_addr_w_i == CSR_MINSTRET);
  assign w_wr_minstreth = csr_we_w_i && (csr_addr_w_i == CSR_MINSTRETH);
  assign w_wr_inhibit   = csr_we_w_i && (csr_addr_w_i == CSR_MCOUNTINHIBIT);
  assign w_wr_status    = csr_we_w_i && (csr_addr_w_i == CSR_MTEST_STATUS);
  assign w_is_terminal  = (csr_wdata_w_i == TEST_PASS_CODE) ||
                          (csr_wdata_w_i == TEST_FAIL_CODE);

  csr_counter64 u_cycle (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (~r_inh_cy),
    .wr_lo_i (w_wr_mcycle),
    .wr_hi_i (w_wr_mcycleh),
    .wdata_i (csr_wdata_w_i),
    .cnt_o   (w_cycle)
  );

  csr_counter64 u_instret (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (w_retire & ~r_inh_ir),
    .wr_lo_i (w_wr_minstret),
    .wr_hi_i (w_wr_minstreth),
    .wdata_i (csr_wdata_w_i),
    .cnt_o   (w_instret)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_inh_cy <= 1'b0;
      r_inh_ir <= 1'b0;
    end else if (w_wr_inhibit) begin
      r_inh_cy <= csr_wdata_w_i[INH_CY_BIT];
      r_inh_ir <= csr_wdata_w_i[INH_IR_BIT];
    end
  end

  // Flags latch only on the first terminal code; the status register keeps tracking writes.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_mtest_status <= '0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
    end else if (w_wr_status) begin
      r_mtest_status <= csr_wdata_w_i;
      if (!r_done && w_is_terminal) begin
        r_done <= 1'b1;
        r_pass <= (csr_wdata_w_i == TEST_PASS_CODE);
      end
    end
  end

  always_comb begin
    csr_rdata_e_o   = '0;
    csr_illegal_e_o = 1'b0;
    case (csr_addr_e_i)
      CSR_MCYCLE:        csr_rdata_e_o = w_cycle[31:0];
      CSR_MCYCLEH:       csr_rdata_e_o = w_cycle[63:32];
      CSR_MINSTRET:      csr_rdata_e_o = w_instret[31:0];
      CSR_MINSTRETH:     csr_rdata_e_o = w_instret[63:32];
      CSR_MCOUNTINHIBIT: begin
        csr_rdata_e_o[INH_CY_BIT] = r_inh_cy;
        csr_rdata_e_o[INH_IR_BIT] = r_inh_ir;
      end
      CSR_MTEST_STATUS:  csr_rdata_e_o = r_mtest_status;
      CSR_CYCLE: begin
        if (HAS_USER_SHADOW) csr_rdata_e_o = w_cycle[31:0];
        else                 csr_illegal_e_o = 1'b1;
      end
      CSR_CYCLEH: begin
        if (HAS_USER_SHADOW) csr_rdata_e_o = w_cycle[63:32];
        else                 csr_illegal_e_o = 1'b1;
      end
      CSR_INSTRET: begin
        if (HAS_USER_SHADOW) csr_rdata_e_o = w_instret[31:0];
        else                 csr_illegal_e_o = 1'b1;
      end
      CSR_INSTRETH: begin
        if (HAS_USER_SHADOW) csr_rdata_e_o = w_instret[63:32];
        else                 csr_illegal_e_o = 1'b1;
      end
      default:           csr_illegal_e_o = 1'b1;
    endcase
  end

  assign test_done_o = r_done;
  assign test_pass_o = r_pass;

endmodule
